// File: rtl/pipe_collision_checker_if.sv
// rtl/pipe_collision_checker_if.sv - control/coordinate bus of the pipe collision checker
//   master drives: enable, frame_tick, clear, y_bird, x_lower, x_upper
//   slave drives : c_flag, hit_pulse, done, hit_index, busy, overrun
interface pipe_collision_checker_if;
  logic         enable;
  logic         frame_tick;
  logic         clear;
  logic [31:0]  y_bird;
  logic [127:0] x_lower;    // pipe i in [32*i+31:32*i]
  logic [127:0] x_upper;
  logic         c_flag;
  logic         hit_pulse;
  logic         done;
  logic [3:0]   hit_index;
  logic         busy;
  logic         overrun;

  modport master (
    output enable, frame_tick, clear, y_bird, x_lower, x_upper,
    input  c_flag, hit_pulse, done, hit_index, busy, overrun
  );

  modport slave (
    input  enable, frame_tick, clear, y_bird, x_lower, x_upper,
    output c_flag, hit_pulse, done, hit_index, busy, overrun
  );
endinterface

// File: rtl/pipe_collision_checker.sv
// rtl/pipe_collision_checker.sv - per-frame bird/pipe/bounds collision engine with sticky flag
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pipe_collision_checker_if (frame control, coordinates, results)
module pipe_collision_checker #(
  parameter int BIRD_X     = 100,
  parameter int BIRD_W     = 20,
  parameter int BIRD_H     = 20,
  parameter int PIPE_W     = 40,
  parameter int GAP_TOP    = 180,
  parameter int GAP_BOTTOM = 300,
  parameter int GROUND_Y   = 440
) (
  input  logic                     clk,
  input  logic                     rst,
  pipe_collision_checker_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_BOUNDS, S_DONE} state_t;

  // Geometry widened to 33 signed bits so every sum is exact.
  localparam logic signed [32:0] BX_L   = 33'(BIRD_X);
  localparam logic signed [32:0] BX_R   = 33'(BIRD_X + BIRD_W);
  localparam logic signed [32:0] PW     = 33'(PIPE_W);
  localparam logic signed [32:0] BH     = 33'(BIRD_H);
  localparam logic signed [32:0] G_TOP  = 33'(GAP_TOP);
  localparam logic signed [32:0] G_BOT  = 33'(GAP_BOTTOM);
  localparam logic signed [32:0] GROUND = 33'(GROUND_Y);

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic               hit_q, hit_d;
  logic [3:0]         src_q, src_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] x_q [8];   // 0-3 lower pipes, 4-7 upper pipes
  logic signed [31:0] x_d [8];
  logic               c_flag_q, c_flag_d;
  logic               overrun_q, overrun_d;
  logic               done_q, done_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic [3:0]         hit_index_q, hit_index_d;

  logic signed [32:0] x_ext, y_ext, y_bot;
  logic               overlap, pipe_hit, ceil_hit, ground_hit, start;

  assign start = bus.frame_tick & bus.enable;

  // Geometry of the entry under scan and of the screen bounds, from the snapshot.
  always_comb begin
    x_ext      = {x_q[idx_q][31], x_q[idx_q]};
    y_ext      = {y_q[31], y_q};
    y_bot      = y_ext + BH;
    overlap    = (BX_L < x_ext + PW) && (x_ext < BX_R);
    pipe_hit   = overlap && (idx_q[2] ? (y_ext < G_TOP) : (y_bot > G_BOT));
    ceil_hit   = y_q[31];
    ground_hit = y_bot > GROUND;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      src_q       <= 4'hF;
      y_q         <= '0;
      for (int i = 0; i < 8; i++) x_q[i] <= '0;
      c_flag_q    <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      hit_pulse_q <= 1'b0;
      hit_index_q <= 4'hF;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      src_q       <= src_d;
      y_q         <= y_d;
      x_q         <= x_d;
      c_flag_q    <= c_flag_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      hit_pulse_q <= hit_pulse_d;
      hit_index_q <= hit_index_d;
    end
  end

  // Next-state logic; clear aborts any scan.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start) state_d = S_SCAN;
        S_SCAN:   if (idx_q == 3'd7) state_d = S_BOUNDS;
        S_BOUNDS: state_d = S_DONE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output register updates.
  always_comb begin
    idx_d       = idx_q;
    hit_d       = hit_q;
    src_d       = src_q;
    y_d         = y_q;
    x_d         = x_q;
    c_flag_d    = c_flag_q;
    overrun_d   = overrun_q;
    hit_index_d = hit_index_q;
    done_d      = 1'b0;
    hit_pulse_d = 1'b0;
    if (bus.clear) begin
      c_flag_d    = 1'b0;
      overrun_d   = 1'b0;
      hit_index_d = 4'hF;
    end else begin
      if (start && state_q != S_IDLE) overrun_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            y_d   = bus.y_bird;
            for (int i = 0; i < 4; i++) begin
              x_d[i]     = bus.x_lower[32*i +: 32];
              x_d[i + 4] = bus.x_upper[32*i +: 32];
            end
            idx_d = '0;
            hit_d = 1'b0;
            src_d = 4'hF;
          end
        end
        S_SCAN: begin
          // Only the first hit is kept; it defines the reported source.
          if (!hit_q && pipe_hit) begin
            hit_d = 1'b1;
            src_d = {1'b0, idx_q};
          end
          idx_d = idx_q + 3'd1;
        end
        S_BOUNDS: begin
          if (!hit_q && ceil_hit) begin
            hit_d = 1'b1;
            src_d = 4'd8;
          end else if (!hit_q && ground_hit) begin
            hit_d = 1'b1;
            src_d = 4'd9;
          end
        end
        default: begin
          done_d      = 1'b1;
          hit_index_d = hit_q ? src_q : 4'hF;
          if (hit_q) begin
            hit_pulse_d = 1'b1;
            c_flag_d    = 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.c_flag    = c_flag_q;
  assign bus.hit_pulse = hit_pulse_q;
  assign bus.done      = done_q;
  assign bus.hit_index = hit_index_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_pipe_collision_checker.sv
// tb/tb_pipe_collision_checker.sv - self-checking bench for pipe_collision_checker
module tb_pipe_collision_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   exp_cflag = 1'b0;

  pipe_collision_checker_if pif();

  pipe_collision_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           y;
    logic [127:0] xl;
    logic [127:0] xu;
    int           exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] p4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  // Reference: first pipe hit in scan order, then ceiling, then ground, else 15.
  function automatic int model(input int y, input logic [127:0] xl, input logic [127:0] xu);
    longint yy, x;
    int xi;
    yy = y;
    for (int p = 0; p < 8; p++) begin
      xi = (p < 4) ? int'(xl[32*p +: 32]) : int'(xu[32*(p-4) +: 32]);
      x  = xi;
      if (100 < x + 40 && x < 120) begin
        if (p < 4 && yy + 20 > 300) return p;
        if (p >= 4 && yy < 180) return p;
      end
    end
    if (yy < 0) return 8;
    if (yy + 20 > 440) return 9;
    return 15;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for done, counting cycles after the start edge; 99 on timeout.
  task automatic wait_done(input int start, output int n);
    n = 99;
    for (int c = start + 1; c <= 20; c++) begin
      cyc();
      if (pif.done) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic add(input int y, input logic [127:0] xl, input logic [127:0] xu, input int exp);
    vec_t v;
    v.y = y; v.xl = xl; v.xu = xu; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic pulse_clear();
    pif.clear = 1'b1;
    cyc();
    pif.clear = 1'b0;
    exp_cflag = 1'b0;
  endtask

  // One full frame from tick to done; optional scrambling of inputs mid-scan.
  task automatic run_frame(input string tag, input int y, input logic [127:0] xl,
                           input logic [127:0] xu, input int exp, input bit scramble);
    int lat;
    pif.y_bird = y; pif.x_lower = xl; pif.x_upper = xu;
    pif.frame_tick = 1'b1;
    cyc();
    pif.frame_tick = 1'b0;
    check({tag, " busy"}, pif.busy, 1);
    if (scramble) begin
      pif.y_bird  = $urandom;
      pif.x_lower = {$urandom, $urandom, $urandom, $urandom};
      pif.x_upper = {$urandom, $urandom, $urandom, $urandom};
    end
    wait_done(0, lat);
    if (exp != 15) exp_cflag = 1'b1;
    check({tag, " latency"}, lat, 10);
    check({tag, " hit_index"}, pif.hit_index, exp);
    check({tag, " hit_pulse"}, pif.hit_pulse, (exp != 15));
    check({tag, " c_flag"}, pif.c_flag, exp_cflag);
    check({tag, " busy_end"}, pif.busy, 0);
    cyc();
    check({tag, " done_one_cycle"}, pif.done, 0);
  endtask

  localparam logic [127:0] FAR = {4{32'sd400}};

  initial begin
    int lat, cnt, y;
    logic [127:0] xl, xu;

    pif.enable = 1'b1; pif.frame_tick = 1'b0; pif.clear = 1'b0;
    pif.y_bird = 200; pif.x_lower = FAR; pif.x_upper = FAR;
    #12;
    check("reset c_flag", pif.c_flag, 0);
    check("reset hit_index", pif.hit_index, 15);
    check("reset busy", pif.busy, 0);
    check("reset done", pif.done, 0);
    check("reset hit_pulse", pif.hit_pulse, 0);
    check("reset overrun", pif.overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Hand-derived vectors (bird x 100..120, gap 180..300, ground 440).
    add(200, FAR, FAR, 15);
    add(290, p4(400, 400, 90, 400), FAR, 2);
    add(150, p4(60, 400, 400, 400), p4(400, 110, 400, 400), 5);
    add(290, p4(60, 400, 400, 400), FAR, 15);
    add(290, p4(119, 400, 400, 400), FAR, 0);
    add(290, p4(400, 400, 400, 120), FAR, 15);
    add(-5, FAR, FAR, 8);
    add(421, FAR, FAR, 9);
    add(420, FAR, FAR, 15);
    add(179, FAR, p4(400, 400, 400, 81), 7);
    add(180, FAR, p4(400, 400, 400, 81), 15);
    add(430, p4(400, 400, 400, 100), FAR, 3);
    add(-5, FAR, p4(100, 400, 400, 400), 4);
    add(290, p4(32'h8000_0000, 32'h7FFF_FFFF, -70, 400), FAR, 15);
    add(32'h7FFF_FFFF, FAR, FAR, 9);
    foreach (vecs[i]) begin
      pulse_clear();
      run_frame($sformatf("vec%0d", i), vecs[i].y, vecs[i].xl, vecs[i].xu, vecs[i].exp, 1'b0);
    end

    // Sticky flag across clean frames, then clear.
    pulse_clear();
    run_frame("sticky_hit", 290, p4(400, 400, 90, 400), FAR, 2, 1'b0);
    for (int k = 0; k < 3; k++) run_frame($sformatf("sticky%0d", k), 200, FAR, FAR, 15, 1'b0);
    pulse_clear();
    check("clear c_flag", pif.c_flag, 0);
    check("clear hit_index", pif.hit_index, 15);

    // Overrun: second tick at T+3, done still at T+10.
    pif.y_bird = 290; pif.x_lower = p4(400, 400, 90, 400); pif.x_upper = FAR;
    pif.frame_tick = 1'b1; cyc(); pif.frame_tick = 1'b0;
    cyc(); cyc();
    pif.frame_tick = 1'b1; cyc(); pif.frame_tick = 1'b0;
    check("overrun set", pif.overrun, 1);
    wait_done(3, lat);
    check("overrun latency", lat, 10);
    check("overrun hit_index", pif.hit_index, 2);
    check("overrun c_flag", pif.c_flag, 1);
    // Clear with simultaneous tick: everything cleared, no scan.
    pif.clear = 1'b1; pif.frame_tick = 1'b1; cyc();
    pif.clear = 1'b0; pif.frame_tick = 1'b0;
    exp_cflag = 1'b0;
    check("clr_tick overrun", pif.overrun, 0);
    check("clr_tick c_flag", pif.c_flag, 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (pif.busy || pif.done) cnt++;
      cyc();
    end
    check("clr_tick no scan", cnt, 0);

    // Tick with enable low is ignored without overrun.
    pif.enable = 1'b0; pif.frame_tick = 1'b1; cyc(); pif.frame_tick = 1'b0;
    check("disabled busy", pif.busy, 0);
    check("disabled overrun", pif.overrun, 0);

    // Enable falling mid-scan: scan completes.
    pif.enable = 1'b1;
    pif.y_bird = -5; pif.x_lower = FAR; pif.x_upper = FAR;
    pif.frame_tick = 1'b1; cyc(); pif.frame_tick = 1'b0;
    pif.enable = 1'b0;
    wait_done(0, lat);
    pif.enable = 1'b1;
    check("enable_drop latency", lat, 10);
    check("enable_drop hit_index", pif.hit_index, 8);
    exp_cflag = 1'b1;

    // Clear mid-scan aborts without done.
    pif.y_bird = 421;
    pif.frame_tick = 1'b1; cyc(); pif.frame_tick = 1'b0;
    cyc(); cyc(); cyc();
    pulse_clear();
    check("abort busy", pif.busy, 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (pif.done) cnt++;
      cyc();
    end
    check("abort no done", cnt, 0);

    // Reset mid-scan after an earlier hit.
    run_frame("pre_reset", 290, p4(400, 400, 90, 400), FAR, 2, 1'b0);
    pif.frame_tick = 1'b1; cyc(); pif.frame_tick = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    check("midreset c_flag", pif.c_flag, 0);
    check("midreset busy", pif.busy, 0);
    check("midreset hit_index", pif.hit_index, 15);
    @(negedge clk);
    rst = 1'b0;
    exp_cflag = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (pif.done) cnt++;
    end
    check("midreset no done", cnt, 0);

    // Randomised frames against the reference model, inputs scrambled mid-scan.
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 7) == 0) pulse_clear();
      y = int'($urandom_range(0, 540)) - 40;
      for (int p = 0; p < 4; p++) begin
        xl[32*p +: 32] = ($urandom_range(0, 3) == 0) ? 32'(55 + $urandom_range(0, 70))
                                                     : 32'(int'($urandom_range(0, 900)) - 200);
        xu[32*p +: 32] = ($urandom_range(0, 3) == 0) ? 32'(55 + $urandom_range(0, 70))
                                                     : 32'(int'($urandom_range(0, 900)) - 200);
      end
      run_frame($sformatf("rand%0d", f), y, xl, xu, model(y, xl, xu), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_collision_checker.md
Name: pipe_collision_checker

Overview:
- Per-frame collision engine for the Flappy-style game. It drives the c_flag consumed by the regfile (exposed to software) and by vga_controller.
- On each frame tick it snapshots the bird y and the eight pipe x positions (lowerpipe1-4, upperpipe1-4). It scans them sequentially against fixed geometry, checks screen bounds, and raises a sticky collision flag.
- It sits between the regfile register taps and the regfile/VGA c_flag input.

Parameters:
- BIRD_X, 100, left x of bird sprite (fixed column)
- BIRD_W, 20, bird width in pixels
- BIRD_H, 20, bird height in pixels
- PIPE_W, 40, pipe width in pixels
- GAP_TOP, 180, y of bottom edge of every upper pipe
- GAP_BOTTOM, 300, y of top edge of every lower pipe
- GROUND_Y, 440, y of ground line

Ports:
- clock  in  1  system clock (single domain)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  game running; when low, frame_tick is ignored
- frame_tick  in  1  one-cycle pulse per frame
- clear  in  1  synchronous clear of sticky flag (game restart)
- y_bird  in  32  bird top y (signed)
- x_lower  in  4x32 (128, pipe0 in [31:0])  lower pipe left x values (signed)
- x_upper  in  4x32 (128)  upper pipe left x values (signed)
- c_flag  out  1  sticky collision flag
- hit_pulse  out  1  one-cycle pulse when a scan finds a collision
- done  out  1  one-cycle pulse at end of every scan
- hit_index  out  4  source of first hit: 0-3 lower pipe i, 4-7 upper pipe i-4, 8 ceiling, 9 ground, 15 none
- busy  out  1  high while a scan is in progress
- overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Reset (async, active-high): all outputs 0, except hit_index = 15. FSM goes to IDLE.
- FSM states: IDLE, SCAN, BOUNDS, DONE.
- IDLE:
  - frame_tick & enable: on that edge, snapshot all 9 coordinate inputs, set idx = 0, clear the internal hit, go to SCAN, busy = 1.
- SCAN: one entry per cycle, idx 0..7.
  - Entries 0-3 use x_lower[idx]; entries 4-7 use x_upper[idx-4].
  - Horizontal overlap: (BIRD_X < x + PIPE_W) && (x < BIRD_X + BIRD_W).
  - Lower-pipe hit: overlap && (y_bird + BIRD_H > GAP_BOTTOM).
  - Upper-pipe hit: overlap && (y_bird < GAP_TOP).
  - First hit records its idx; later hits do not overwrite it.
  - After idx 7, go to BOUNDS.
- BOUNDS (one cycle):
  - Ceiling hit if y_bird < 0, recorded as 8.
  - Ground hit if y_bird + BIRD_H > GROUND_Y, recorded as 9.
  - Either is recorded only if no pipe hit was already recorded.
- DONE (one cycle):
  - done = 1. hit_index updates (15 if none).
  - If a hit was found: hit_pulse = 1 and c_flag is set.
  - busy = 0. Return to IDLE.
- Latency: frame_tick sampled at edge T gives SCAN on T+1..T+8, BOUNDS on T+9, and done/hit_pulse/c_flag all visible after edge T+10.
- Arithmetic:
  - All compares are signed 32-bit, so pipes with negative x (scrolled off-screen) work.
  - Sums are computed in 33 bits, so there is no overflow wrap.
  - Edges that exactly touch do not count as a hit (strict inequalities).
- Snapshot isolation: input changes during a scan do not affect the result.
- frame_tick while busy: ignored, overrun set (sticky until clear or reset).
- frame_tick while enable = 0: ignored, no overrun.
- clear:
  - Clears c_flag and overrun, sets hit_index = 15, aborts any scan to IDLE (no done pulse). Takes priority over everything.
  - A frame_tick in the same cycle as clear is dropped.
- enable falling mid-scan: the scan completes normally.
- c_flag stays set across frames until clear or reset. hit_pulse repeats on every subsequent hitting frame.

Test Plan:
- Reset mid-scan: assert reset at T+4 -> c_flag = 0, busy = 0, hit_index = 15 immediately; no done pulse.
- Clear scan: y_bird = 200, all x = 400, frame_tick -> done at T+10, hit_pulse = 0, c_flag = 0, hit_index = 15.
- Lower-pipe hit: y_bird = 290, x_lower[2] = 90, others 400 -> hit_index = 2, hit_pulse at T+10, c_flag = 1 and stays 1 over 3 further clear frames (y_bird = 200) until clear pulses.
- Priority: y_bird = 150, x_upper[1] = 110, x_lower[0] = 60 -> hit_index = 5. Touching-edge case: x_lower[0] = 60 alone with y_bird = 290 -> no hit (60 + 40 = 100).
- Bounds: y_bird = -5, all x = 400 -> hit_index = 8; y_bird = 421 -> hit_index = 9; y_bird = 420 -> none.
- Overrun/clear: second frame_tick at T+3 -> ignored, overrun = 1, done still at T+10. Then clear and frame_tick in the same cycle -> overrun = 0, c_flag = 0, no scan starts.
